// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, xtime and common constants.
// Used by the key expander and the cipher/inverse-cipher datapaths.
package aes_pkg;

    localparam int AES_NB = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } kex_state_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_subword.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
// Purely combinational.
module aes_subword
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);

    assign sub[31:24] = sbox(word[31:24]);
    assign sub[23:16] = sbox(word[23:16]);
    assign sub[15:8]  = sbox(word[15:8]);
    assign sub[7:0]   = sbox(word[7:0]);

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule: one word per clock, stored
// in a word array and read back a round key at a time.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int Nb = AES_NB,
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [32*Nk-1:0]  key,
    output logic              busy,
    output logic              done,
    output logic              keys_valid,
    input  logic [3:0]        rk_addr,
    output logic [32*Nb-1:0]  rk_data
);

    localparam int NW = Nb * (Nr + 1);
    localparam int IW = $clog2(NW);

    kex_state_t state, state_nx;

    logic [IW-1:0] i;
    logic [2:0]    kc;
    logic [7:0]    rcon;
    logic          kv;
    logic [31:0]   w [NW];

    logic [31:0] prev, old, sub_in, sub_out, w_new;
    logic        load, last;

    assign load = (state == IDLE) && start;
    assign last = (i == IW'(NW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = EXPAND;
            EXPAND:  if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // kc follows i mod Nk so no divider is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i    <= '0;
            kc   <= '0;
            rcon <= 8'h01;
            kv   <= 1'b0;
        end else if (load) begin
            i    <= IW'(Nk);
            kc   <= '0;
            rcon <= 8'h01;
            kv   <= 1'b0;
        end else if (state == EXPAND) begin
            i  <= i + IW'(1);
            kc <= (kc == 3'(Nk - 1)) ? 3'd0 : kc + 3'd1;
            if (kc == 3'd0) rcon <= xtime(rcon);
            if (last) kv <= 1'b1;
        end
    end

    // Word storage carries no reset; keys_valid qualifies it.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int j = 0; j < Nk; j++)
                w[j] <= key[32*(Nk-1-j) +: 32];
        end else if (state == EXPAND) begin
            w[i] <= w_new;
        end
    end

    assign prev   = w[i - IW'(1)];
    assign old    = w[i - IW'(Nk)];
    assign sub_in = (kc == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_subword u_subword (
        .word (sub_in),
        .sub  (sub_out)
    );

    always_comb begin
        w_new = old ^ prev;
        unique case (1'b1)
            (kc == 3'd0):
                w_new = old ^ sub_out ^ {rcon, 24'h0};
            (Nk == 8 && kc == 3'd4):
                w_new = old ^ sub_out;
            default:
                w_new = old ^ prev;
        endcase
    end

    always_comb begin
        rk_data = '0;
        if (rk_addr <= 4'(Nr)) begin
            for (int j = 0; j < Nb; j++)
                rk_data[32*(Nb-1-j) +: 32] =
                    w[IW'({rk_addr, 2'b00}) + IW'(j)];
        end
    end

    assign busy       = (state == EXPAND);
    assign done       = (state == DONE);
    assign keys_valid = kv;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander at Nk=4/6/8 against a
// FIPS-197 model whose S-box is derived from GF(2^8).
module tb_aes_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   rk_addr;
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic         start [3];
    logic         busy  [3];
    logic         done  [3];
    logic         kv    [3];
    logic [127:0] rd    [3];

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mw  [60];
    logic [7:0]  sbt [256];

    always #5 clk = ~clk;

    aes_key_expander #(.Nk(4), .Nr(10)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .key(key4),
        .busy(busy[0]), .done(done[0]), .keys_valid(kv[0]),
        .rk_addr(rk_addr), .rk_data(rd[0]));

    aes_key_expander #(.Nk(6), .Nr(12)) u6 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .key(key6),
        .busy(busy[1]), .done(done[1]), .keys_valid(kv[1]),
        .rk_addr(rk_addr), .rk_data(rd[1]));

    aes_key_expander #(.Nk(8), .Nr(14)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .key(key8),
        .busy(busy[2]), .done(done[2]), .keys_valid(kv[2]),
        .rk_addr(rk_addr), .rk_data(rd[2]));

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int n = 0; n < 8; n++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] b, int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2)
                   ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(logic [31:0] t);
        return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
    endfunction

    // Textbook KeyExpansion; key is left-aligned in 256 bits.
    task automatic model(input logic [255:0] k, input int nk, input int nr);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int j = 0; j < nk; j++) mw[j] = k[255-32*j -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic int nk_of(int d);
        return 4 + 2 * d;
    endfunction

    function automatic int nr_of(int d);
        return 10 + 2 * d;
    endfunction

    task automatic set_key(input int d, input logic [255:0] k);
        case (d)
            0:       key4 = k[255 -: 128];
            1:       key6 = k[255 -: 192];
            default: key8 = k;
        endcase
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
        return k;
    endfunction

    task automatic run(input int d, input logic [255:0] k, input int alt_at,
                       input logic [255:0] alt_k, input string tag);
        int n = 0;
        int nk = nk_of(d);
        int nw = 4 * (nr_of(d) + 1);
        model(k, nk, nr_of(d));
        @(negedge clk);
        set_key(d, k);
        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk({tag, " busy after start"}, 256'(busy[d]), 256'(1));
        chk({tag, " kv after start"}, 256'(kv[d]), 256'(0));
        while (done[d] !== 1'b1 && n < 200) begin
            if (n == alt_at) begin
                set_key(d, alt_k);
                start[d] = 1'b1;
            end
            @(negedge clk);
            start[d] = 1'b0;
            n++;
        end
        chk({tag, " latency"}, 256'(n), 256'(nw - nk));
        chk({tag, " busy at done"}, 256'(busy[d]), 256'(0));
        chk({tag, " kv at done"}, 256'(kv[d]), 256'(1));
        @(negedge clk);
        chk({tag, " done one cycle"}, 256'(done[d]), 256'(0));
        chk({tag, " kv held"}, 256'(kv[d]), 256'(1));
    endtask

    task automatic check_keys(input int d, input string tag);
        int nr = nr_of(d);
        for (int r = 0; r <= nr; r++) begin
            @(negedge clk);
            rk_addr = 4'(r);
            #1;
            chk($sformatf("%s rk%0d", tag, r), 256'(rd[d]),
                256'({mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]}));
        end
        for (int r = nr + 1; r <= 15; r += 15 - nr) begin
            @(negedge clk);
            rk_addr = 4'(r);
            #1;
            chk($sformatf("%s rk%0d zero", tag, r), 256'(rd[d]), 256'(0));
        end
        chk({tag, " kv idle"}, 256'(kv[d]), 256'(1));
    endtask

    task automatic peek(input int d, input int r, input logic [127:0] exp,
                        input string tag);
        @(negedge clk);
        rk_addr = 4'(r);
        #1;
        chk(tag, 256'(rd[d]), 256'(exp));
    endtask

    initial begin
        logic [255:0] k;
        rst_n = 1'b0;
        rk_addr = '0;
        key4 = '0;
        key6 = '0;
        key8 = '0;
        for (int d = 0; d < 3; d++) start[d] = 1'b0;
        build_sbox();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset busy%0d", d), 256'(busy[d]), 256'(0));
            chk($sformatf("reset done%0d", d), 256'(done[d]), 256'(0));
            chk($sformatf("reset kv%0d", d), 256'(kv[d]), 256'(0));
        end
        rst_n = 1'b1;

        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        run(0, k, -1, '0, "nk4 fips");
        check_keys(0, "nk4 fips");
        peek(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, "nk4 fips kat10");
        peek(0, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c, "nk4 fips kat0");

        k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        run(0, k, -1, '0, "nk4 seq");
        peek(0, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "nk4 seq kat10");

        k = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        run(1, k, -1, '0, "nk6 seq");
        check_keys(1, "nk6 seq");
        peek(1, 12, 128'ha4970a331a78dc09c418c271e3a41d5d, "nk6 seq kat12");

        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        run(2, k, -1, '0, "nk8 seq");
        check_keys(2, "nk8 seq");
        peek(2, 14, 128'h24fc79ccbf0979e9371ac23c6d68de36, "nk8 seq kat14");

        for (int d = 0; d < 3; d++) begin
            run(d, rand_key(), -1, '0, $sformatf("rand%0d", d));
            check_keys(d, $sformatf("rand%0d", d));
        end

        run(0, rand_key(), 10, rand_key(), "nk4 repulse");
        check_keys(0, "nk4 repulse");

        @(negedge clk);
        key4 = rand_key()[255 -: 128];
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset busy", 256'(busy[0]), 256'(0));
        chk("midreset kv", 256'(kv[0]), 256'(0));
        chk("midreset done", 256'(done[0]), 256'(0));
        chk("midreset kv nk8", 256'(kv[2]), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run(0, rand_key(), -1, '0, "post reset");
        check_keys(0, "post reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
AES_KEY_EXPANDER -- requirements
Module: aes_key_expander

Interface
REQ-001 SHALL have parameter Nb, default 4, meaning words per state column block.
REQ-002 SHALL have parameter Nk, default 4, meaning key words; legal values are 4, 6 and 8.
REQ-003 SHALL have parameter Nr, default 10, meaning round count; legal values are 10, 12 and 14.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; it is asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, a request to expand the key.
REQ-007 SHALL have port key, input, 32*Nk bits, the cipher key; w[0] = key[32*Nk-1 -: 32] (MSB-first).
REQ-008 SHALL have port busy, output, 1 bit, high while expansion is in progress.
REQ-009 SHALL have port done, output, 1 bit, a one-cycle pulse when the schedule is complete.
REQ-010 SHALL have port keys_valid, output, 1 bit, high while the stored schedule is complete and current.
REQ-011 SHALL have port rk_addr, input, 4 bits, the round index 0..Nr.
REQ-012 SHALL have port rk_data, output, 32*Nb bits, round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, with w[4r] in the MSBs.

Function
REQ-013 SHALL implement FIPS-197 KeyExpansion, storing Nb*(Nr+1) 32-bit words (44, 52 or 60).
REQ-014 SHALL use FSM states IDLE, EXPAND and DONE; reset enters IDLE.
REQ-015 SHALL, in IDLE with start=1, write w[0..Nk-1] from key in one edge, set i=Nk, busy=1, keys_valid=0, and go to EXPAND.
REQ-016 SHALL, in EXPAND, write exactly one word w[i] per edge and then increment i.
- i mod Nk == 0: w[i] = w[i-Nk] ^ SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}
- Nk==8 and i mod 8 == 4: w[i] = w[i-8] ^ SubWord(w[i-1])
- otherwise: w[i] = w[i-Nk] ^ w[i-1]
REQ-017 SHALL track i mod Nk with a wrapping counter; no divider is permitted.
REQ-018 SHALL hold Rcon in a register that starts at 8'h01 and is updated by xtime (x2 mod 0x11B) after each use, giving the sequence 01,02,04,...,80,1b,36.
REQ-019 SHALL, on the edge writing the last word, move to DONE, deassert busy and assert done for exactly one cycle.
REQ-020 SHALL make the latency from the start edge to done high equal to Nb*(Nr+1)-Nk edges (40, 46 or 52).
REQ-021 SHALL, in DONE, hold keys_valid=1 and go to IDLE on the next edge; keys_valid stays 1 until the next accepted start.
REQ-022 SHALL ignore start while busy=1; key changes during expansion have no effect.
REQ-023 SHALL accept a start asserted in the DONE cycle on the following IDLE edge only.
REQ-024 SHALL drive rk_data combinationally from storage for rk_addr<=Nr, and drive all zeros for rk_addr>Nr.
REQ-025 SHALL leave rk_data for addresses unaffected by the current expansion undefined to consumers; consumers use it only when keys_valid=1.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-expansion, immediately force state=IDLE, busy=0, done=0, keys_valid=0, i=0 and Rcon=8'h01.
REQ-027 SHALL not require reset of the word storage; its contents are don't-care until keys_valid=1.

Structure
REQ-028 SHALL take the S-box table function, the Nb constant and the xtime function from shared package aes_pkg, which is shared with cipher/inversecipher.
REQ-029 SHALL place SubWord in one sub-module aes_subword (four parallel S-box lookups, combinational) and instantiate it once.
REQ-030 SHALL keep the implementation within 120-400 RTL lines with no multipliers or dividers.

Verification
REQ-031 SHALL cover: Nk=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> done after 40 cycles; rk_addr=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6, rk_addr=0 gives the key.
REQ-032 SHALL cover: Nk=4, key 000102030405060708090a0b0c0d0e0f -> rk_addr=10 gives 13111d7fe3944a17f307a78b4d2b30c5.
REQ-033 SHALL cover: Nk=6/Nr=12, key 000102...1617 -> done after 46 cycles; rk_addr=12 gives a4970a331a78dc09c418c271e3a41d5d.
REQ-034 SHALL cover: Nk=8/Nr=14, key 000102...1e1f -> done after 52 cycles; rk_addr=14 gives 24fc79ccbf0979e9371ac23c6d68de36.
REQ-035 SHALL cover: start re-pulsed at cycle 10 of expansion -> ignored and done still at cycle 40; rst_n low at cycle 20 -> busy=0 and keys_valid=0 at once; a new start then completes correctly.
REQ-036 SHALL cover: rk_addr=15 with keys_valid=1 -> rk_data is all zeros; done is high for exactly one cycle in every run.
